// File: rtl/ws_ctrl_pkg.sv
// Shared types and elaboration helpers for the weight-stationary array controller.
// Counter widths and per-lane delay depths are computed here so every file agrees on them.
package ws_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } ws_ctrl_state_t;

  // Delay-line depth selectors for ws_skew_line.
  localparam int SKEW_IN    = 0;
  localparam int SKEW_OUT   = 1;
  localparam int SKEW_FIXED = 2;

  function automatic int cnt_width(input int max_val);
    int w;
    w = (max_val < 1) ? 1 : $clog2(max_val + 1);
    return w;
  endfunction

  // Input skew: row i sees i+1 registers. Output deskew: column j gets N-1-j.
  function automatic int skew_depth(input int mode, input int lane, input int lanes,
                                    input int fixed_depth);
    int d;
    case (mode)
      SKEW_IN:  d = lane + 1;
      SKEW_OUT: d = lanes - 1 - lane;
      default:  d = fixed_depth;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ws_skew_line.sv
// Per-lane shift-register delay line; lane depth comes from ws_ctrl_pkg::skew_depth.
// Zero-depth lanes are plain wires.
module ws_skew_line
  import ws_ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int LANES       = 4,
  parameter int MODE        = SKEW_IN,
  parameter int FIXED_DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES*W-1:0] in_data,
  output logic [LANES*W-1:0] out_data
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DEPTH = skew_depth(MODE, l, LANES, FIXED_DEPTH);

    if (DEPTH == 0) begin : g_wire
      assign out_data[l*W +: W] = in_data[l*W +: W];
    end else begin : g_regs
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
          stage[0] <= in_data[l*W +: W];
          for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
      end

      assign out_data[l*W +: W] = stage[DEPTH-1];
    end
  end

endmodule

// File: rtl/ws_array_ctrl.sv
// Sequencer for an NxN weight-stationary systolic array: weight load, skewed activation
// streaming, deskewed result capture. Define WS_CTRL_PERF_EN to build the perf counters.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid never waits on ready, and r_valid has no backpressure.
module ws_array_ctrl
  import ws_ctrl_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 4,
  parameter int K_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] num_vec,
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [N*D_W-1:0]           w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [N*D_W-1:0]           a_data,
  output logic                       r_valid,
  output logic                       r_last,
  output logic [N*2*D_W-1:0]         r_data,
  output logic                       arr_load_weight,
  output logic [N*D_W-1:0]           arr_m1,
  output logic [N*D_W-1:0]           arr_m0,
  input  logic [N*2*D_W-1:0]         arr_m2,
  output logic [31:0]                perf_active_cnt,
  output logic [31:0]                perf_bubble_cnt,
  output logic [2:0]                 dbg_state
);

  localparam int KW = cnt_width(K_MAX);
  localparam int RW = cnt_width(N);

  ws_ctrl_state_t  state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   k_sat;
  logic [RW-1:0]   row_cnt;
  logic [KW-1:0]   vec_cnt;
  logic [KW-1:0]   res_cnt;
  logic            w_fire;
  logic            a_fire;
  logic            last_in;
  logic [1:0]      tag_out;
  logic [N*D_W-1:0]   inject;
  logic [N*2*D_W-1:0] deskewed;

  assign k_sat   = (num_vec > KW'(K_MAX)) ? KW'(K_MAX) : num_vec;
  assign w_ready = (state == S_LOAD_W);
  assign a_ready = (state == S_STREAM) && (vec_cnt < k_reg);
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;
  assign last_in = a_fire && (vec_cnt == k_reg - KW'(1));

  assign arr_load_weight = w_fire;
  assign arr_m1          = w_fire ? w_data : '0;
  // Non-handshake cycles push a zero column so the skew line keeps moving.
  assign inject          = a_fire ? a_data : '0;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      k_reg   <= '0;
      row_cnt <= '0;
      vec_cnt <= '0;
      res_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_valid) res_cnt <= res_cnt + KW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD_W;
            k_reg   <= k_sat;
            row_cnt <= '0;
            vec_cnt <= '0;
            res_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_LOAD_W: begin
          if (w_fire) begin
            row_cnt <= row_cnt + RW'(1);
            if (row_cnt == RW'(N - 1)) state <= (k_reg == '0) ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (a_fire) begin
            vec_cnt <= vec_cnt + KW'(1);
            if (vec_cnt == k_reg - KW'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Every tagged column emerges as exactly one r_valid, so counting them tells us the pipe is empty.
          if (res_cnt == k_reg) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ws_skew_line #(
    .W(D_W), .LANES(N), .MODE(SKEW_IN), .FIXED_DEPTH(1)
  ) u_skew (
    .clk(clk), .rst(rst), .in_data(inject), .out_data(arr_m0)
  );

  ws_skew_line #(
    .W(2*D_W), .LANES(N), .MODE(SKEW_OUT), .FIXED_DEPTH(1)
  ) u_deskew (
    .clk(clk), .rst(rst), .in_data(arr_m2), .out_data(deskewed)
  );

  // Tag and last flag ride the full skew + array + deskew path length.
  ws_skew_line #(
    .W(2), .LANES(1), .MODE(SKEW_FIXED), .FIXED_DEPTH(2*N)
  ) u_tag (
    .clk(clk), .rst(rst), .in_data({last_in, a_fire}), .out_data(tag_out)
  );

  assign r_valid = tag_out[0];
  assign r_last  = tag_out[1];
  assign r_data  = r_valid ? deskewed : '0;

`ifdef WS_CTRL_PERF_EN
  logic [31:0] active_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      bubble_q <= '0;
    end else if (state == S_IDLE && start) begin
      active_q <= '0;
      bubble_q <= '0;
    end else begin
      if (busy && active_q != '1) active_q <= active_q + 32'd1;
      if (state == S_STREAM && !a_fire && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign perf_active_cnt = active_q;
  assign perf_bubble_cnt = bubble_q;
`else
  assign perf_active_cnt = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Directed bench for ws_array_ctrl with a behavioural NxN weight-stationary array attached.
// Expected results come from a direct matrix-vector product on the bench's own weight copy.
module tb_ws_array_ctrl;

  localparam int D_W   = 8;
  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int RW2   = 2 * D_W;
  localparam int EW    = 16 + 1 + N * RW2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                start, busy, done;
  logic [KW-1:0]       num_vec;
  logic                w_valid, w_ready, a_valid, a_ready;
  logic [N*D_W-1:0]    w_data, a_data, arr_m1, arr_m0;
  logic                r_valid, r_last, arr_load_weight;
  logic [N*RW2-1:0]    r_data, arr_m2;
  logic [31:0]         perf_active_cnt, perf_bubble_cnt;
  logic [2:0]          dbg_state;

  ws_array_ctrl #(.D_W(D_W), .N(N), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_last(r_last), .r_data(r_data),
    .arr_load_weight(arr_load_weight), .arr_m1(arr_m1), .arr_m0(arr_m0), .arr_m2(arr_m2),
    .perf_active_cnt(perf_active_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural systolic array ----------------
  logic [D_W-1:0] pe_w   [N][N];
  logic [D_W-1:0] pe_act [N][N];
  logic [RW2-1:0] pe_sum [N][N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          pe_w[r][c]   <= '0;
          pe_act[r][c] <= '0;
          pe_sum[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (arr_load_weight)
            pe_w[r][c] <= (r == 0) ? arr_m1[c*D_W +: D_W] : pe_w[(r == 0) ? 0 : r-1][c];
          pe_act[r][c] <= (c == 0) ? arr_m0[r*D_W +: D_W] : pe_act[r][(c == 0) ? 0 : c-1];
          pe_sum[r][c] <= ((r == 0) ? RW2'(0) : pe_sum[(r == 0) ? 0 : r-1][c])
                        + RW2'((c == 0) ? arr_m0[r*D_W +: D_W] : pe_act[r][(c == 0) ? 0 : c-1])
                        * RW2'(pe_w[r][c]);
        end
    end
  end

  always_comb begin
    arr_m2 = '0;
    for (int c = 0; c < N; c++) arr_m2[c*RW2 +: RW2] = pe_sum[N-1][c];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]  exp_q [$];
  logic [EW-1:0]  e;
  logic [D_W-1:0] wmat [N][N];
  int tests_run = 0;
  int fail_cnt  = 0;
  int rv_cnt    = 0;
  int done_cnt  = 0;
  int last_a_cyc = 0;
  int last_w_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*RW2-1:0] model_mac(input logic [N*D_W-1:0] a);
    logic [N*RW2-1:0] res;
    logic [RW2-1:0]   s;
    res = '0;
    for (int j = 0; j < N; j++) begin
      s = '0;
      for (int i = 0; i < N; i++) s = s + RW2'(a[i*D_W +: D_W]) * RW2'(wmat[i][j]);
      res[j*RW2 +: RW2] = s;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (r_valid === 1'b1) begin
        rv_cnt++;
        tests_run++;
        assert (exp_q.size() != 0) else begin
          fail_cnt++;
          $error("FAIL unexpected_r_valid: observed r_valid=1 r_data=%0h expected no result", r_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("r_data", r_data, e[N*RW2-1:0]);
          check("r_last", r_last, e[N*RW2]);
          check("r_latency_cycle", cyc[15:0], e[EW-1 -: 16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_weights(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (mode)
          0:       wmat[i][j] = (i == j) ? D_W'(1) : D_W'(0);
          1:       wmat[i][j] = D_W'(2);
          2:       wmat[i][j] = D_W'(255);
          default: wmat[i][j] = D_W'($urandom_range(0, 255));
        endcase
  endtask

  task automatic start_tile(input int kreq);
    start = 1'b1;
    num_vec = KW'(kreq);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("state_load_w", dbg_state, 1);
  endtask

  // Rows go out N-1 first so the first one ends up in the bottom array row.
  task automatic load_weights(input bit stall);
    int t;
    for (int r = N-1; r >= 0; r--) begin
      if (stall) begin
        w_valid = 1'b0;
        @(negedge clk);
        check("stall_load_weight", arr_load_weight, 0);
        check("stall_arr_m1", arr_m1, 0);
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      for (int c = 0; c < N; c++) w_data[c*D_W +: D_W] = wmat[r][c];
      t = 0;
      @(negedge clk);
      while (w_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      check("w_ready", w_ready, 1);
      check("load_weight_on_fire", arr_load_weight, 1);
      check("arr_m1_on_fire", arr_m1, w_data);
      last_w_cyc = cyc;
      @(posedge clk); #1;
      w_valid = 1'b0;
      w_data  = '0;
    end
  endtask

  task automatic send_act(input logic [N*D_W-1:0] d, input bit last);
    int t;
    a_valid = 1'b1;
    a_data  = d;
    t = 0;
    @(negedge clk);
    while (a_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    tests_run++;
    assert (a_ready === 1'b1) else begin
      fail_cnt++;
      $error("FAIL a_ready_timeout: observed a_ready=%b expected 1", a_ready);
    end
    if (a_ready === 1'b1) begin
      exp_q.push_back({16'(cyc + 2*N), last, model_mac(d)});
      last_a_cyc = cyc;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data  = '0;
  endtask

  task automatic wait_done(input int exp_cyc);
    int t;
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("done_seen", done, 1);
    check("done_cycle", 64'(cyc), 64'(exp_cyc));
    check("busy_low_with_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("state_idle_after", dbg_state, 0);
  endtask

  // pat: 0 = counting values, 1 = all ones, 2 = all 255, 3 = random
  task automatic run_tile(input int kreq, input int keff, input int pat, input bit stall,
                          input int gap_at, input int gap_len);
    logic [N*D_W-1:0] v_data;
    int exp_done;
    rv_cnt = 0;
    start_tile(kreq);
    load_weights(stall);
    for (int v = 0; v < keff; v++) begin
      if (v == gap_at) begin
        a_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      for (int i = 0; i < N; i++)
        case (pat)
          0:       v_data[i*D_W +: D_W] = D_W'(v*N + i + 1);
          1:       v_data[i*D_W +: D_W] = D_W'(1);
          2:       v_data[i*D_W +: D_W] = D_W'(255);
          default: v_data[i*D_W +: D_W] = D_W'($urandom_range(0, 255));
        endcase
      send_act(v_data, v == keff - 1);
    end
    check("a_ready_low_after_k", a_ready, 0);
    // A start outside IDLE must be ignored.
    start = 1'b1;
    num_vec = KW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    exp_done = (keff == 0) ? last_w_cyc + 2 : last_a_cyc + 2*N + 2;
    wait_done(exp_done);
    check("r_valid_count", 64'(rv_cnt), 64'(keff));
    check("queue_drained", 64'(exp_q.size()), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dsnap, rsnap;
    start = 1'b0; num_vec = '0;
    a_valid = 1'b0; a_data = '0;
    w_valid = 1'b1; w_data = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_load_weight", arr_load_weight, 0);
    check("rst_arr_m1", arr_m1, 0);
    check("rst_arr_m0", arr_m0, 0);
    check("rst_state", dbg_state, 0);
    check("rst_perf_bubble", perf_bubble_cnt, 0);
    w_valid = 1'b0; w_data = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // identity weights: results echo the activations
    set_weights(0);
    run_tile(4, 4, 0, 1'b0, -1, 0);

    // stalled weight load, all-2 weights, all-1 activations -> 8 per column
    set_weights(1);
    run_tile(2, 2, 1, 1'b1, -1, 0);

    // 3-cycle activation gap mid-stream
    set_weights(1);
    run_tile(6, 6, 0, 1'b0, 3, 3);
`ifdef WS_CTRL_PERF_EN
    check("perf_bubble_cnt", perf_bubble_cnt, 3);
`else
    check("perf_bubble_cnt", perf_bubble_cnt, 0);
`endif

    // empty tile
    set_weights(3);
    run_tile(0, 0, 0, 1'b0, -1, 0);
    check("busy_after_k0", busy, 0);

    // full-scale values wrap in the 16-bit column sums (63492)
    set_weights(2);
    run_tile(3, 3, 2, 1'b0, -1, 0);

    // reset mid-stream aborts the tile
    set_weights(0);
    rv_cnt = 0;
    start_tile(8);
    load_weights(1'b0);
    for (int v = 0; v < 3; v++) send_act(D_W'(v + 1) * {N{8'h01}}, 1'b0);
    rst = 1'b0;
    #1;
    check("abort_r_valid", r_valid, 0);
    check("abort_r_data", r_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_arr_m0", arr_m0, 0);
    check("abort_a_ready", a_ready, 0);
    check("abort_state", dbg_state, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dsnap = done_cnt;
    rsnap = rv_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(dsnap));
    check("abort_no_r_valid", 64'(rv_cnt), 64'(rsnap));

    // clean tile after the abort; num_vec above K_MAX saturates to 16
    set_weights(3);
    run_tile(20, K_MAX, 3, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL global_timeout: observed no finish, expected finish before limit");
  end

endmodule

// File: doc/ws_array_ctrl.md
# ws_array_ctrl

Sequencing controller for the N×N weight-stationary systolic array. It accepts a weight tile and then a stream of activation vectors over valid/ready interfaces, and drives the array's `load_weight`, `m1` (vertical weight load) and `m0` (horizontal activation) inputs. Activations are skewed on the way in, and the `m2` column sums are deskewed on the way out, so each result vector is emitted aligned with its activation vector. It sits between the tile buffers/DMA and the array instance.

## Interface
- `D_W`, 8, activation/weight element width
- `N`, 4, array dimension (rows = columns)
- `K_MAX`, 16, max activation vectors per tile
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin tile; sampled only in IDLE
- `num_vec`  in  $clog2(K_MAX+1)  K, number of activation vectors; sampled with `start`
- `busy`  out  1  high from `start` acceptance until `done`
- `done`  out  1  one-cycle pulse when the tile completes
- `w_valid`/`w_ready`  in/out  1  weight-row handshake
- `w_data`  in  N×D_W  one weight row
- `a_valid`/`a_ready`  in/out  1  activation-vector handshake
- `a_data`  in  N×D_W  element i feeds array row i
- `r_valid`  out  1  result valid; no backpressure
- `r_last`  out  1  marks the result of vector K-1
- `r_data`  out  N×2·D_W  deskewed column sums
- `arr_load_weight`  out  1  to array `load_weight`
- `arr_m1`  out  N×D_W  to array `m1`
- `arr_m0`  out  N×D_W  to array `m0`
- `arr_m2`  in  N×2·D_W  from array `m2`
- `perf_active_cnt`, `perf_bubble_cnt`  out  32 each  performance counters (see Configuration)

## Operation
- Array contract:
  - With `load_weight` high, each PE latches `in_weight` and passes it down one row per cycle.
  - `out_act` and `out_sum` are registered with a one-cycle hop latency.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - `w_ready` = `a_ready` = 0.
  - `start` → LOAD_W; latches `num_vec` and clears the row and vector counters.
- LOAD_W:
  - `w_ready` = 1.
  - Each accepted row: `arr_m1` = `w_data`, and `arr_load_weight` = 1 in that same cycle.
  - Cycles without a handshake: `arr_load_weight` = 0, `arr_m1` = 0, weights hold.
  - The first row accepted lands in array row N-1, so upstream sends rows N-1 down to 0.
  - After N rows: → STREAM, or → DRAIN if K = 0.
- STREAM:
  - `a_ready` = 1 while the vector counter < K.
  - Each cycle injects one column into the skew line: `a_data` on handshake, otherwise an all-zero bubble.
  - A tag bit travels with the column: 1 for real data, 0 for a bubble.
  - After the K-th accept: → DRAIN.
- Skew: element i of the injected column reaches `arr_m0[i]` after i+1 registers (row 0 is registered once).
- Deskew: `arr_m2[j]` is delayed by N-1-j registers, so all columns align.
- The tag follows the same total path. `r_valid` = tag; bubbles never produce `r_valid`.
- `r_last` is asserted with the result whose tag index equals K-1.
- DRAIN: waits until the tag pipeline is empty, then → DONE.
- DONE: `done` = 1 for one cycle → IDLE. `busy` drops in the same cycle `done` is high.
- `start` while not IDLE is ignored.
- Width rules:
  - Sums are not truncated: `r_data` passes the full 2·D_W array output.
  - Counters are sized $clog2(K_MAX+1) and $clog2(N+1).
  - `num_vec` > K_MAX saturates to K_MAX.

## Timing
- Reset values (asynchronous): every output 0, FSM IDLE, all skew/deskew/tag registers 0.
- Reset asserted mid-tile aborts the tile: no `done`, no further `r_valid`.
- Latency: an activation accepted at cycle c produces `r_valid` at cycle c+2N (8 for N=4).
- Throughput: one vector per cycle with `a_valid` held high; K vectors finish (`done`) at cycle c0+K-1+2N+2, where c0 is the first accept.
- Weight load: N handshake cycles minimum; stalls are tolerated with no weight corruption.
- `a_valid` is ignored in LOAD_W. The LOAD_W→STREAM transition is registered, so the first possible activation accept is in the cycle after the N-th weight accept.

## Configuration
- `WS_CTRL_PERF_EN` defined:
  - `perf_active_cnt` counts cycles with `busy`.
  - `perf_bubble_cnt` counts bubble injections in STREAM.
  - Both clear on `start` and saturate at 2^32-1.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Structure
- `ws_ctrl_pkg`:
  - state enum `ws_ctrl_state_t`
  - `function` for the skew depth of row i
  - localparam helpers for counter widths
- Sub-module `ws_skew_line`:
  - Parameterised per-lane delay line (width, lanes, depth function select).
  - Instantiated for input skew, output deskew and the tag/last pipeline.

## Test plan
- Identity weights (W = I), K=4, `a_data` rows {1,2,3,4},{5,6,7,8}… → `r_data` equals the inputs, first `r_valid` 8 cycles after first accept, `r_last` on the 4th.
- `w_valid` toggling every other cycle during LOAD_W, weights all 2, activation {1,1,1,1} → `r_data` = {8,8,8,8}; weights unaffected by the stalls.
- `a_valid` low for 3 cycles mid-stream, K=6 → exactly 6 `r_valid` pulses; `perf_bubble_cnt` = 3 with `WS_CTRL_PERF_EN`, 0 without.
- K=0 → N weight rows accepted, no `r_valid`, `done` after drain, `busy` low afterwards.
- Max values, D_W=8: weights 255, activations 255 → each `r_data` column = 4·255·255 = 260100, which exceeds the 16-bit result width, so expect 260100 mod 65536 = 63492 (wrap, not saturate).
- `rst` low during STREAM → all outputs 0 immediately, no `done`; a subsequent `start` runs a clean tile.
